// File: rtl/tx_frame_shifter.sv
// ============================================================================
// tx_frame_shifter : single-buffer frame serialiser (start, NBIT LSB-first, parity)
// Rev 1.0 | optional macro TX_PARITY_ODD_EN selects odd parity
// ============================================================================
`default_nettype none

module tx_frame_shifter #(
  parameter int NBIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce_bit,
  input  logic            st,
  input  logic            en_tx,
  input  logic            T_cp,
  input  logic [NBIT-1:0] din,
  input  logic            we,
  input  logic            clr_ovr,
  output logic            full,
  output logic            ovr,
  output logic            sync_err,
  output logic            txd,
  output logic            busy,
  output logic            tx_done
);

  localparam int              c_SW        = $clog2(NBIT + 2);
  localparam logic [c_SW-1:0] c_PAR_SLOT  = c_SW'(NBIT);
  localparam logic [c_SW-1:0] c_STOP_SLOT = c_SW'(NBIT + 1);

`ifdef TX_PARITY_ODD_EN
  localparam logic c_PAR_INV = 1'b1;
`else
  localparam logic c_PAR_INV = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t          r_state;
  logic [NBIT-1:0] r_buf;
  logic [NBIT-1:0] r_sr;
  logic [c_SW-1:0] r_slot;
  logic            r_par;
  logic            r_full;
  logic            r_ovr;
  logic            r_sync_err;
  logic            r_txd;
  logic            r_busy;
  logic            r_tx_done;
  logic            r_en_q;

  logic w_wr_ok;
  logic w_wr_ovr;
  logic w_load;
  logic w_abort;
  logic w_bit;
  logic w_misalign;

  // Write and load are judged against the pre-edge full flag, so they never collide.
  assign w_wr_ok    = we & ~r_full;
  assign w_wr_ovr   = we & r_full;
  assign w_load     = (r_state == S_IDLE) & st & r_full;
  assign w_abort    = (r_state == S_SEND) & r_en_q & ~en_tx & (r_slot != c_STOP_SLOT);
  assign w_bit      = (r_state == S_SEND) & ce_bit & ~w_abort;
  assign w_misalign = w_bit & (T_cp != (r_slot == c_PAR_SLOT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_sr       <= '0;
      r_slot     <= '0;
      r_par      <= 1'b0;
      r_full     <= 1'b0;
      r_ovr      <= 1'b0;
      r_sync_err <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_en_q     <= 1'b0;
    end else begin
      r_en_q    <= en_tx;
      r_tx_done <= 1'b0;

      if (w_wr_ok) begin
        r_buf  <= din;
        r_full <= 1'b1;
      end else if (w_load) begin
        r_full <= 1'b0;
      end

      // Set events are applied after the clear so they win on a tie.
      if (clr_ovr) begin
        r_ovr      <= 1'b0;
        r_sync_err <= 1'b0;
      end
      if (w_wr_ovr) r_ovr <= 1'b1;
      if (w_abort | w_misalign) r_sync_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_sr    <= r_buf;
            r_par   <= 1'b0;
            r_slot  <= '0;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_abort) begin
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (ce_bit) begin
            if (r_slot != c_STOP_SLOT) r_slot <= r_slot + 1'b1;
            if (r_slot < c_PAR_SLOT) begin
              r_txd <= r_sr[0];
              r_sr  <= r_sr >> 1;
              r_par <= r_par ^ r_sr[0];
            end else if (r_slot == c_PAR_SLOT) begin
              r_txd <= r_par ^ c_PAR_INV;
            end else begin
              r_txd     <= 1'b1;
              r_busy    <= 1'b0;
              r_tx_done <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign full     = r_full;
  assign ovr      = r_ovr;
  assign sync_err = r_sync_err;
  assign txd      = r_txd;
  assign busy     = r_busy;
  assign tx_done  = r_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_tx_frame_shifter.sv
// ============================================================================
// tb_tx_frame_shifter : randomized directed bench with a frame-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tx_frame_shifter;

  localparam int N = 8;

`ifdef TX_PARITY_ODD_EN
  localparam logic c_ODD = 1'b1;
`else
  localparam logic c_ODD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, ce_bit, st, en_tx, T_cp, we, clr_ovr;
  logic [N-1:0] din;
  logic         full, ovr, sync_err, txd, busy, tx_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: the holding buffer and sticky flags.
  logic         m_full, m_ovr, m_sync;
  logic [N-1:0] m_buf;

  tx_frame_shifter #(.NBIT(N)) dut (
    .clk(clk), .rst(rst), .ce_bit(ce_bit), .st(st), .en_tx(en_tx), .T_cp(T_cp),
    .din(din), .we(we), .clr_ovr(clr_ovr), .full(full), .ovr(ovr),
    .sync_err(sync_err), .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(input logic [N-1:0] w);
    return logic'(($countones(w) % 2) == 1) ^ c_ODD;
  endfunction

  task automatic model_write(input logic [N-1:0] w);
    if (m_full) m_ovr = 1'b1;
    else begin
      m_buf  = w;
      m_full = 1'b1;
    end
  endtask

  task automatic do_write(input logic [N-1:0] w);
    we = 1'b1; din = w;
    tick();
    we = 1'b0;
    model_write(w);
    check("full_after_write", full, m_full);
    check("ovr_after_write", ovr, m_ovr);
  endtask

  task automatic do_clear();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    m_ovr = 1'b0; m_sync = 1'b0;
    check("ovr_cleared", ovr, 1'b0);
    check("sync_cleared", sync_err, 1'b0);
  endtask

  // One timer frame. ab_kind: 0 none, 1 en_tx drop, 2 reset, applied before bit strobe ab_slot.
  task automatic run_frame(input bit tcp_bad, input int ab_kind, input int ab_slot,
                           input bit wr_st, input logic [N-1:0] wd);
    bit           sending;
    logic [N-1:0] word;
    logic         tc, expb;
    sending = m_full;
    word    = m_buf;
    st = 1'b1; ce_bit = 1'b1; en_tx = 1'b1; T_cp = 1'b0; we = wr_st; din = wd;
    tick();
    st = 1'b0; ce_bit = 1'b0; we = 1'b0;
    if (sending) m_full = 1'b0;
    if (wr_st) begin
      if (sending) m_ovr = 1'b1;
      else begin m_buf = wd; m_full = 1'b1; end
    end
    check("start_txd", txd, !sending);
    check("start_busy", busy, sending);
    check("start_full", full, m_full);
    check("start_ovr", ovr, m_ovr);
    for (int k = 0; k <= N + 1; k++) begin
      tc   = tcp_bad ? 1'b0 : (k == N);
      T_cp = tc;
      repeat ($urandom_range(3, 1)) tick();
      if (ab_kind != 0 && k == ab_slot) begin
        if (ab_kind == 1) begin
          en_tx = 1'b0;
          tick();
          if (sending) m_sync = 1'b1;
          check("abort_txd", txd, 1'b1);
          check("abort_busy", busy, 1'b0);
          check("abort_done", tx_done, 1'b0);
          check("abort_sync", sync_err, m_sync);
          repeat (3) tick();
          check("abort_no_done", tx_done, 1'b0);
        end else begin
          we = 1'b1; din = N'($urandom);
          tick();
          we = 1'b0;
          model_write(din);
          check("midframe_full", full, m_full);
          rst = 1'b1;
          tick();
          rst = 1'b0;
          m_full = 1'b0; m_ovr = 1'b0; m_sync = 1'b0;
          check("rst_txd", txd, 1'b1);
          check("rst_full", full, 1'b0);
          check("rst_busy", busy, 1'b0);
          check("rst_sync", sync_err, 1'b0);
        end
        T_cp = 1'b0; en_tx = 1'b0;
        tick();
        return;
      end
      ce_bit = 1'b1;
      tick();
      ce_bit = 1'b0;
      if (sending && (tc != (k == N))) m_sync = 1'b1;
      if (!sending)    expb = 1'b1;
      else if (k < N)  expb = word[k];
      else if (k == N) expb = exp_par(word);
      else             expb = 1'b1;
      check($sformatf("txd_slot%0d", k), txd, expb);
      check($sformatf("busy_slot%0d", k), busy, sending && (k <= N));
      check($sformatf("done_slot%0d", k), tx_done, sending && (k == N + 1));
    end
    tick();
    check("done_single_pulse", tx_done, 1'b0);
    T_cp = 1'b0;
    repeat (3) tick();
    en_tx = 1'b0;
    tick();
    check("end_sync", sync_err, m_sync);
    check("end_ovr", ovr, m_ovr);
    check("end_full", full, m_full);
  endtask

  initial begin
    rst = 1'b1; ce_bit = 1'b0; st = 1'b0; en_tx = 1'b0; T_cp = 1'b0;
    we = 1'b0; clr_ovr = 1'b0; din = '0;
    m_full = 1'b0; m_ovr = 1'b0; m_sync = 1'b0; m_buf = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_full", full, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_sync", sync_err, 1'b0);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);

    // Known-pattern frame.
    do_write(8'hA5);
    repeat (4) tick();
    run_frame(0, 0, 0, 0, '0);

    // Overrun keeps the first word.
    do_write(8'h01);
    do_write(8'hFF);
    run_frame(0, 0, 0, 0, '0);
    do_clear();

    // Empty frame.
    run_frame(0, 0, 0, 0, '0);

    // Write coincident with start: idle frame, then the word goes out.
    run_frame(0, 0, 0, 1, 8'h3C);
    run_frame(0, 0, 0, 0, '0);

    // Parity-slot misalignment, then en_tx abort in data slot 3.
    do_write(N'($urandom));
    run_frame(1, 0, 0, 0, '0);
    do_clear();
    do_write(N'($urandom));
    run_frame(0, 1, 4, 0, '0);
    do_clear();

    // Reset during data slot 5 with a word buffered.
    do_write(N'($urandom));
    run_frame(0, 2, 6, 0, '0);

    // Randomized traffic.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(2, 0)) do_write(N'($urandom));
      if ($urandom_range(3, 0) == 0) do_clear();
      run_frame(($urandom_range(4, 0) == 0), 0, 0, ($urandom_range(1, 0) == 1), N'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tx_frame_shifter.md
Name: tx_frame_shifter

Overview:
- Serialiser stage directly downstream of the transmit bit timer; consumes its ce_bit, st, en_tx and T_cp strobes.
- Holds one data word from the ADC side in a single-entry buffer. Emits a frame on txd: start bit (0), NBIT data bits LSB first, then one parity bit. The line stays idle-high through the timer's pause.
- Reports overrun and timer/shifter slot misalignment as sticky flags.

Parameters:
- NBIT, 8: data bits per frame, range 1..16.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- ce_bit, in, 1: bit-boundary strobe from the timer, one clk wide.
- st, in, 1: frame-start strobe; always coincides with ce_bit.
- en_tx, in, 1: timer frame-active level.
- T_cp, in, 1: timer parity-slot level.
- din, in, NBIT: data word to transmit.
- we, in, 1: write strobe for din into the holding buffer.
- clr_ovr, in, 1: clears ovr and sync_err.
- full, out, 1: holding buffer occupied.
- ovr, out, 1: sticky overrun flag.
- sync_err, out, 1: sticky timer/shifter misalignment flag.
- txd, out, 1: serial line, registered.
- busy, out, 1: frame in progress.
- tx_done, out, 1: one-clk pulse when the parity slot ends.

Behaviour:
- Reset values: full=0, ovr=0, sync_err=0, txd=1, busy=0, tx_done=0. The shift register, slot counter and parity accumulator are all cleared.
- Reset mid-frame aborts the frame and drops any buffered word. txd is 1 on the next clk.
- All outputs are registered. Every change below takes effect one clk after the qualifying edge.
- Buffer write:
  - we & !full: buf<=din, full<=1.
  - we & full: din is discarded, buf is unchanged, ovr<=1.
- State machine: IDLE, SEND.
- IDLE, st & full:
  - Load: sr<=buf, full<=0, par<=0, slot<=0.
  - txd<=0 (start bit), busy<=1, go to SEND.
- IDLE, st & !full:
  - No frame is sent; txd stays 1 for the whole timer frame (empty frame).
- Same-cycle we & st, full=0: the word enters buf but is not sent in this frame; full=1 afterwards.
- Same-cycle we & st, full=1: the old buf is loaded and the new din is dropped with ovr<=1. The write is evaluated against the pre-edge full value.
- SEND, on each ce_bit (st ignored in SEND), slot<=slot+1:
  - slot 0..NBIT-1: txd<=sr[0], sr<=sr>>1, par<=par^sr[0].
  - slot NBIT: txd<=parity bit (even parity: par).
  - slot NBIT+1: txd<=1, busy<=0, tx_done<=1, go to IDLE.
  - The slot counter is ceil(log2(NBIT+2)) bits wide and never wraps.
- Alignment check, in SEND:
  - ce_bit ending slot NBIT with T_cp=0 -> sync_err<=1.
  - ce_bit in any other slot with T_cp=1 -> sync_err<=1.
- en_tx falling to 0 while in SEND before slot NBIT+1: abort, txd<=1, busy<=0, sync_err<=1, no tx_done.
- clr_ovr clears ovr and sync_err. A set event in the same cycle as clr_ovr wins.
- Latency: txd start bit appears 1 clk after the st edge. The line then advances on each ce_bit.

Optional Feature:
- Macro: TX_PARITY_ODD_EN.
- Defined: parity slot carries ~par (odd parity; the count of ones over data plus parity is odd).
- Undefined: parity slot carries par (even parity).
- No other behaviour changes.

Test Plan:
1. Frame content, even parity, NBIT=8:
   - Stimulus: rst; we with din=8'hA5; st after 4 clk.
   - Required: full 1->0 on the st edge; txd sequence per ce_bit 0,1,0,1,0,0,1,0,1, parity 0, then 1.
   - Required: tx_done pulses exactly once; busy falls with it.
2. Overrun:
   - Stimulus: we din=8'h01, then we din=8'hFF before st.
   - Required: ovr=1; transmitted data is 8'h01, parity 1.
   - Required: clr_ovr -> ovr=0.
3. Empty frame:
   - Stimulus: st with full=0.
   - Required: txd stays 1 for the whole frame; busy=0, tx_done=0.
4. Simultaneous write and start:
   - Stimulus: we din=8'h3C on the same cycle as st, full=0.
   - Required: idle frame; full=1; 8'h3C is sent on the next st.
5. Misalignment and abort:
   - Stimulus: hold T_cp=0 through the parity slot.
   - Required: sync_err=1, frame still completes.
   - Stimulus: drop en_tx in data slot 3.
   - Required: txd=1, busy=0, no tx_done, sync_err=1.
6. Reset and option:
   - Stimulus: assert rst during data slot 5.
   - Required: txd=1, full=0, busy=0 on the next clk.
   - Stimulus: rebuild with TX_PARITY_ODD_EN, send 8'hA5.
   - Required: parity bit 1.
